// File: rtl/lpc_pkg.sv
// Shared LPC definitions for the TwPM host and peripheral: FSM state
// encoding, cycle types, SYNC nibble values and response error codes.
package lpc_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_START,
        ST_CYCTYPE,
        ST_ADDR0,
        ST_ADDR1,
        ST_ADDR2,
        ST_ADDR3,
        ST_WDATA0,
        ST_WDATA1,
        ST_HTAR0,
        ST_HTAR1,
        ST_SYNC,
        ST_RDATA0,
        ST_RDATA1,
        ST_PTAR0,
        ST_PTAR1,
        ST_ABORT,
        ST_ABORT_REL,
        ST_DONE
    } lpc_state_e;

    localparam logic [3:0] CYC_IO_RD  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SYNC    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_INVALID = 2'b11;

    // A short or long wait keeps the cycle alive without being an error.
    function automatic logic isSyncWait(input logic [3:0] nibble);
        return (nibble == SYNC_SHORT) || (nibble == SYNC_LONG);
    endfunction

endpackage

// File: rtl/lpc_sync_watchdog.sv
// SYNC phase decoder and wait timer. Classifies the sampled LAD nibble and
// flags a timeout on the SYNC clock that brings the non-ready count up to
// SYNC_TIMEOUT.
module lpc_sync_watchdog
    import lpc_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 32
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       i_clear,
    input  logic       i_active,
    input  logic [3:0] i_lad,
    output logic       o_ready,
    output logic       o_wait,
    output logic [1:0] o_errCode,
    output logic       o_timeout
);

    localparam int            TW          = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(SYNC_TIMEOUT);

    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timerNext;
    logic          w_notReady;

    // Decode the current SYNC nibble and look ahead one count for the timeout.
    always_comb begin
        o_ready     = (i_lad == SYNC_READY) || (i_lad == SYNC_ERROR);
        o_wait      = isSyncWait(i_lad);
        w_notReady  = i_active && !o_ready;
        w_timerNext = r_timer + 1'b1;
        o_timeout   = w_notReady && (w_timerNext == TIMEOUT_VAL);
        o_errCode   = ERR_OK;
        if (i_active) begin
            if (i_lad == SYNC_ERROR) begin
                o_errCode = ERR_SYNC;
            end else if (!o_ready && !o_wait) begin
                o_errCode = ERR_INVALID;
            end
        end
    end

    // Count non-ready SYNC clocks; cleared at the start of every cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_timer <= '0;
        end else if (i_clear) begin
            r_timer <= '0;
        end else if (w_notReady) begin
            r_timer <= w_timerNext;
        end
    end

endmodule

// File: rtl/lpc_host_tpm_master.sv
// LPC host initiator for single-byte TPM I/O cycles. Turns a command/response
// handshake into START/CYCTYPE/ADDR/DATA/TAR/SYNC phases on LAD/LFRAME#.
// Optional build macro LPC_HOST_ABORT_EN: on SYNC timeout drive a 4-clock
// LFRAME# abort frame before releasing the bus; otherwise just release it.
module lpc_host_tpm_master
    import lpc_pkg::*;
#(
    parameter int         SYNC_TIMEOUT = 32,
    parameter logic [3:0] START_NIBBLE = 4'h5
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [15:0] cmd_addr_i,
    input  logic [7:0]  cmd_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic [1:0]  rsp_err_o,
    output logic        lframe_o,
    output logic [3:0]  lad_o,
    output logic        lad_oe_o,
    input  logic [3:0]  lad_i
);

    lpc_state_e  r_state;
    lpc_state_e  w_stateNext;
    logic        r_write;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic [1:0]  r_err;
    logic [7:0]  r_rspData;
    logic [1:0]  r_rspErr;
    logic        w_syncReady;
    logic        w_syncWait;
    logic        w_syncTimeout;
    logic [1:0]  w_syncErrCode;
`ifdef LPC_HOST_ABORT_EN
    logic [1:0]  r_abortCnt;
`endif

    lpc_sync_watchdog #(
        .SYNC_TIMEOUT(SYNC_TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .i_clear  (r_state == ST_START),
        .i_active (r_state == ST_SYNC),
        .i_lad    (lad_i),
        .o_ready  (w_syncReady),
        .o_wait   (w_syncWait),
        .o_errCode(w_syncErrCode),
        .o_timeout(w_syncTimeout)
    );

    assign rsp_data_o = r_rspData;
    assign rsp_err_o  = r_rspErr;

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and bus drive; outputs decode straight from the state so an
    // async reset releases the bus immediately.
    always_comb begin
        w_stateNext = r_state;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        lframe_o    = 1'b1;
        lad_o       = 4'hF;
        lad_oe_o    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) w_stateNext = ST_START;
            end
            ST_START: begin
                lframe_o    = 1'b0;
                lad_o       = START_NIBBLE;
                lad_oe_o    = 1'b1;
                w_stateNext = ST_CYCTYPE;
            end
            ST_CYCTYPE: begin
                lad_o       = r_write ? CYC_IO_WR : CYC_IO_RD;
                lad_oe_o    = 1'b1;
                w_stateNext = ST_ADDR0;
            end
            ST_ADDR0: begin
                lad_o       = r_addr[15:12];
                lad_oe_o    = 1'b1;
                w_stateNext = ST_ADDR1;
            end
            ST_ADDR1: begin
                lad_o       = r_addr[11:8];
                lad_oe_o    = 1'b1;
                w_stateNext = ST_ADDR2;
            end
            ST_ADDR2: begin
                lad_o       = r_addr[7:4];
                lad_oe_o    = 1'b1;
                w_stateNext = ST_ADDR3;
            end
            ST_ADDR3: begin
                lad_o       = r_addr[3:0];
                lad_oe_o    = 1'b1;
                w_stateNext = r_write ? ST_WDATA0 : ST_HTAR0;
            end
            ST_WDATA0: begin
                lad_o       = r_wdata[3:0];
                lad_oe_o    = 1'b1;
                w_stateNext = ST_WDATA1;
            end
            ST_WDATA1: begin
                lad_o       = r_wdata[7:4];
                lad_oe_o    = 1'b1;
                w_stateNext = ST_HTAR0;
            end
            ST_HTAR0: begin
                lad_oe_o    = 1'b1;
                w_stateNext = ST_HTAR1;
            end
            ST_HTAR1:  w_stateNext = ST_SYNC;
            ST_SYNC: begin
                if (w_syncTimeout) begin
`ifdef LPC_HOST_ABORT_EN
                    w_stateNext = ST_ABORT;
`else
                    w_stateNext = ST_ABORT_REL;
`endif
                end else if (w_syncReady) begin
                    w_stateNext = r_write ? ST_PTAR0 : ST_RDATA0;
                end
            end
            ST_RDATA0: w_stateNext = ST_RDATA1;
            ST_RDATA1: w_stateNext = ST_PTAR0;
            ST_PTAR0:  w_stateNext = ST_PTAR1;
            ST_PTAR1:  w_stateNext = ST_DONE;
            ST_ABORT: begin
`ifdef LPC_HOST_ABORT_EN
                lframe_o = 1'b0;
                lad_oe_o = 1'b1;
                if (r_abortCnt == 2'd3) w_stateNext = ST_ABORT_REL;
`else
                w_stateNext = ST_ABORT_REL;
`endif
            end
            ST_ABORT_REL: w_stateNext = ST_DONE;
            ST_DONE: begin
                rsp_valid_o = 1'b1;
                w_stateNext = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Command capture, SYNC error tracking, read data sampling and the
    // response registers that hold until the next response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= ERR_OK;
            r_rspData <= 8'hFF;
            r_rspErr  <= ERR_OK;
        end else begin
            if ((r_state == ST_IDLE) && cmd_valid_i) begin
                r_write <= cmd_write_i;
                r_addr  <= cmd_addr_i;
                r_wdata <= cmd_data_i;
            end
            case (r_state)
                ST_START: r_err <= ERR_OK;
                ST_SYNC: begin
                    if (w_syncTimeout) begin
                        r_err <= w_syncWait ? ERR_TIMEOUT : w_syncErrCode;
                    end else if (w_syncErrCode == ERR_SYNC) begin
                        r_err <= ERR_SYNC;
                    end
                end
                ST_RDATA0: r_rdata[3:0] <= lad_i;
                ST_RDATA1: r_rdata[7:4] <= lad_i;
                ST_PTAR1, ST_ABORT_REL: begin
                    r_rspErr  <= r_err;
                    r_rspData <= (r_write || (r_err != ERR_OK)) ? 8'hFF : r_rdata;
                end
                default: ;
            endcase
        end
    end

`ifdef LPC_HOST_ABORT_EN
    // Length of the abort frame.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_abortCnt <= '0;
        end else if (r_state == ST_ABORT) begin
            r_abortCnt <= r_abortCnt + 2'd1;
        end else begin
            r_abortCnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_lpc_host_tpm_master.sv
// Testbench for lpc_host_tpm_master. A protocol-level model builds the
// expected per-clock bus picture and peripheral replies for each command.
module tb_lpc_host_tpm_master;

    localparam int SYNC_TIMEOUT = 32;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [15:0] cmd_addr_i;
    logic [7:0]  cmd_data_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic [1:0]  rsp_err_o;
    logic        lframe_o;
    logic [3:0]  lad_o;
    logic        lad_oe_o;
    logic [3:0]  lad_i;

    int checks = 0;
    int errors = 0;

    logic [3:0] syncScript[$];
    logic [7:0] expBus[0:127];
    logic [3:0] expDrive[0:127];
    int         expLen;

    lpc_host_tpm_master #(
        .SYNC_TIMEOUT(SYNC_TIMEOUT),
        .START_NIBBLE(4'h5)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i),
        .cmd_addr_i (cmd_addr_i),
        .cmd_data_i (cmd_data_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_data_o (rsp_data_o),
        .rsp_err_o  (rsp_err_o),
        .lframe_o   (lframe_o),
        .lad_o      (lad_o),
        .lad_oe_o   (lad_oe_o),
        .lad_i      (lad_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected bus entry: {cmd_ready, rsp_valid, lframe, oe, lad (only when oe)}.
    task automatic pushBus(input logic lf, input logic oe, input logic [3:0] lad, input logic [3:0] drv);
        expBus[expLen]   = {2'b00, lf, oe, (oe ? lad : 4'h0)};
        expDrive[expLen] = drv;
        expLen++;
    endtask

    // Called at a falling edge with the DUT idle; returns at the idle falling edge after DONE.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                                 input logic [7:0] rdata, input bit holdValid, output int latency);
        int         nonReady;
        bit         timedOut;
        logic [1:0] expErr;
        logic [7:0] expData;
        logic [7:0] obsBus;
        logic [3:0] n;
        expLen   = 0;
        nonReady = 0;
        timedOut = 0;
        expErr   = 2'b00;
        pushBus(1'b0, 1'b1, 4'h5, 4'hF);
        pushBus(1'b1, 1'b1, (wr ? 4'h2 : 4'h0), 4'hF);
        for (int i = 3; i >= 0; i--) pushBus(1'b1, 1'b1, addr[i*4 +: 4], 4'hF);
        if (wr) begin
            pushBus(1'b1, 1'b1, data[3:0], 4'hF);
            pushBus(1'b1, 1'b1, data[7:4], 4'hF);
        end
        pushBus(1'b1, 1'b1, 4'hF, 4'hF);
        pushBus(1'b1, 1'b0, 4'hF, 4'hF);
        for (int i = 0; i < syncScript.size(); i++) begin
            n = syncScript[i];
            pushBus(1'b1, 1'b0, 4'hF, n);
            if (n == 4'h0 || n == 4'hA) begin
                if (n == 4'hA) expErr = 2'b01;
                break;
            end
            nonReady++;
            if (nonReady == SYNC_TIMEOUT) begin
                timedOut = 1;
                expErr   = (n == 4'h5 || n == 4'h6) ? 2'b10 : 2'b11;
                break;
            end
        end
        if (timedOut) begin
`ifdef LPC_HOST_ABORT_EN
            for (int i = 0; i < 4; i++) pushBus(1'b0, 1'b1, 4'hF, 4'hF);
`endif
            pushBus(1'b1, 1'b0, 4'hF, 4'hF);
        end else begin
            if (!wr) begin
                pushBus(1'b1, 1'b0, 4'hF, rdata[3:0]);
                pushBus(1'b1, 1'b0, 4'hF, rdata[7:4]);
            end
            pushBus(1'b1, 1'b0, 4'hF, 4'hF);
            pushBus(1'b1, 1'b0, 4'hF, 4'hF);
        end
        expData = (wr || expErr != 2'b00) ? 8'hFF : rdata;

        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        cmd_valid_i = 1'b1;
        checkOutput("accept_ready", 32'(cmd_ready_o), 32'd1);
        @(posedge clk_i);
        latency = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (c == 0 && !holdValid) cmd_valid_i = 1'b0;
            if (rsp_valid_o === 1'b1) begin
                latency = c;
                break;
            end
            if (c < expLen) begin
                obsBus = {cmd_ready_o, rsp_valid_o, lframe_o, lad_oe_o, (expBus[c][4] ? lad_o : 4'h0)};
                checkOutput($sformatf("bus_c%0d", c), 32'(obsBus), 32'(expBus[c]));
                lad_i = expDrive[c];
            end else begin
                lad_i = 4'hF;
            end
        end
        lad_i = 4'hF;
        checkOutput("latency", 32'(latency), 32'(expLen));
        checkOutput("rsp_err", 32'(rsp_err_o), 32'(expErr));
        checkOutput("rsp_data", 32'(rsp_data_o), 32'(expData));
        checkOutput("done_bus", 32'({cmd_ready_o, lframe_o, lad_oe_o}), 32'(3'b010));
        @(negedge clk_i);
        checkOutput("post_idle", 32'({cmd_ready_o, rsp_valid_o, lframe_o, lad_oe_o}), 32'(4'b1010));
        checkOutput("post_hold", 32'({rsp_err_o, rsp_data_o}), 32'({expErr, expData}));
    endtask

    initial begin
        int         lat;
        int         pulses;
        int         nW;
        logic [15:0] rAddr;

        rstn_i      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
        lad_i       = 4'hF;
        repeat (3) @(negedge clk_i);
        $display("[TB] reset values");
        checkOutput("rst_ctrl", 32'({cmd_ready_o, rsp_valid_o, lframe_o, lad_oe_o}), 32'(4'b1010));
        checkOutput("rst_lad", 32'(lad_o), 32'h0000000F);
        checkOutput("rst_rsp", 32'({rsp_err_o, rsp_data_o}), 32'h000000FF);
        rstn_i = 1'b1;
        @(negedge clk_i);

        $display("[TB] test 1: write 0x0F00 <= 0xA5");
        syncScript.delete();
        syncScript.push_back(4'h0);
        applyStimulus(1'b1, 16'h0F00, 8'hA5, 8'h00, 1'b0, lat);
        checkOutput("t1_accept_to_rsp", 32'(lat + 1), 32'd14);

        $display("[TB] test 2: read 0x0F18 with three long waits");
        syncScript.delete();
        repeat (3) syncScript.push_back(4'h6);
        syncScript.push_back(4'h0);
        applyStimulus(1'b0, 16'h0F18, 8'h00, 8'h3C, 1'b0, lat);
        checkOutput("t2_accept_to_rsp", 32'(lat + 1), 32'd17);
        checkOutput("t2_data", 32'(rsp_data_o), 32'h3C);

        $display("[TB] test 5: reset during ADDR2");
        rAddr       = 16'($urandom);
        cmd_write_i = 1'b1;
        cmd_addr_i  = rAddr;
        cmd_data_i  = 8'($urandom);
        cmd_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checkOutput("t5_in_addr2", 32'({lframe_o, lad_oe_o, lad_o}), 32'({2'b11, rAddr[7:4]}));
        rstn_i = 1'b0;
        #1;
        checkOutput("t5_rst_bus", 32'({lframe_o, lad_oe_o, cmd_ready_o, rsp_valid_o, lad_o}), 32'({4'b1010, 4'hF}));
        checkOutput("t5_rst_rsp", 32'({rsp_err_o, rsp_data_o}), 32'h000000FF);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o === 1'b1) pulses++;
        end
        checkOutput("t5_no_rsp", 32'(pulses), 32'd0);

        $display("[TB] test 3: read with floating LAD");
        syncScript.delete();
        repeat (SYNC_TIMEOUT) syncScript.push_back(4'hF);
        applyStimulus(1'b0, 16'($urandom), 8'h00, 8'($urandom), 1'b0, lat);

        $display("[TB] timeout with wait nibbles");
        syncScript.delete();
        repeat (SYNC_TIMEOUT) syncScript.push_back(4'h5);
        applyStimulus(1'b1, 16'($urandom), 8'($urandom), 8'h00, 1'b0, lat);

        $display("[TB] one wait short of the timeout");
        syncScript.delete();
        repeat (SYNC_TIMEOUT - 1) syncScript.push_back(4'h6);
        syncScript.push_back(4'h0);
        applyStimulus(1'b0, 16'($urandom), 8'h00, 8'($urandom), 1'b0, lat);

        $display("[TB] test 4: write with SYNC error");
        syncScript.delete();
        syncScript.push_back(4'hA);
        applyStimulus(1'b1, 16'($urandom), 8'($urandom), 8'h00, 1'b0, lat);

        $display("[TB] test 6: back-to-back with valid held");
        syncScript.delete();
        syncScript.push_back(4'h5);
        syncScript.push_back(4'h0);
        applyStimulus(1'b0, 16'($urandom), 8'h00, 8'($urandom), 1'b1, lat);
        syncScript.delete();
        syncScript.push_back(4'h0);
        applyStimulus(1'b1, 16'($urandom), 8'($urandom), 8'h00, 1'b0, lat);

        $display("[TB] randomized commands");
        for (int t = 0; t < 10; t++) begin
            syncScript.delete();
            nW = int'($urandom_range(0, 5));
            for (int w = 0; w < nW; w++) begin
                case ($urandom_range(0, 3))
                    0:       syncScript.push_back(4'h5);
                    1:       syncScript.push_back(4'h6);
                    2:       syncScript.push_back(4'h3);
                    default: syncScript.push_back(4'hC);
                endcase
            end
            syncScript.push_back(($urandom_range(0, 3) == 0) ? 4'hA : 4'h0);
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom), 1'b0, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
